// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, padder state encoding and the tail-word padding helper.
package sha256_pkg;

  localparam int BLOCK_W   = 512;
  localparam int WORD_W    = 32;
  localparam int LEN_W     = 64;
  localparam int NUM_WORDS = BLOCK_W / WORD_W;

  localparam logic [7:0]        PAD_MARKER  = 8'h80;
  localparam logic [WORD_W-1:0] MARKER_WORD = {PAD_MARKER, 24'h0};

  typedef enum logic [1:0] {
    S_ABSORB,
    S_EMIT,
    S_PAD
  } state_e;

  // Keep the first nbytes (left-justified), place the marker right after them.
  // nbytes = 4 leaves the word untouched; the marker then lives in the next word.
  function automatic logic [WORD_W-1:0] pad_tail_word(input logic [WORD_W-1:0] w,
                                                       input logic [2:0]        nbytes);
    case (nbytes)
      3'd0:    return MARKER_WORD;
      3'd1:    return {w[31:24], PAD_MARKER, 16'h0};
      3'd2:    return {w[31:16], PAD_MARKER, 8'h0};
      3'd3:    return {w[31:8], PAD_MARKER};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream input and 512-bit block output of the SHA-256 padder.
interface sha256_padder_if;

  logic                           i_valid;
  logic                           o_ready;
  logic [sha256_pkg::WORD_W-1:0]  i_word;
  logic                           i_last;
  logic [2:0]                     i_nbytes;
  logic                           o_valid;
  logic                           i_ready;
  logic [sha256_pkg::BLOCK_W-1:0] o_block;
  logic                           o_first;
  logic                           o_last;

  modport slave (
    input  i_valid, i_word, i_last, i_nbytes, i_ready,
    output o_ready, o_valid, o_block, o_first, o_last
  );

  modport master (
    output i_valid, i_word, i_last, i_nbytes, i_ready,
    input  o_ready, o_valid, o_block, o_first, o_last
  );

endinterface

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a big-endian word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and flags first/last blocks.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  sha256_padder_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W:0] LAST_LEN_FIT = (IDX_W+1)'(NUM_WORDS - 3);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [LEN_W-1:0]   len_q, len_d, len_sum;
  logic               first_pend_q, first_pend_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pad_after_q, pad_after_d;
  logic               marker_q, marker_d;

  logic [WORD_W-1:0]  buf_q [NUM_WORDS];
  logic [WORD_W-1:0]  wdata [NUM_WORDS];
  logic [NUM_WORDS-1:0] we;

  logic               accept;
  logic [IDX_W:0]     marker_idx;
  logic               len_fits;

  assign bus.o_valid = (state_q == S_EMIT);
  assign bus.o_ready = (state_q == S_ABSORB) && !bus.o_valid;
  assign bus.o_first = first_q;
  assign bus.o_last  = last_q;

  assign accept  = bus.i_valid && bus.o_ready;
  assign len_sum = len_q + LEN_W'({bus.i_nbytes, 3'b000});

  // A full final beat pushes the marker one word further, possibly past word 15.
  assign marker_idx = {1'b0, widx_q} + ((bus.i_nbytes >= 3'd4) ? (IDX_W+1)'(1) : '0);
  assign len_fits   = (marker_idx <= LAST_LEN_FIT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    widx_d       = widx_q;
    len_d        = len_q;
    first_pend_d = first_pend_q;
    first_d      = first_q;
    last_d       = last_q;
    pad_after_d  = pad_after_q;
    marker_d     = marker_q;
    we           = '0;
    for (int i = 0; i < NUM_WORDS; i++) wdata[i] = '0;

    case (state_q)
      S_ABSORB: begin
        if (accept) begin
          len_d = len_sum;
          if (!bus.i_last) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (IDX_W'(i) == widx_q) begin
                we[i]    = 1'b1;
                wdata[i] = bus.i_word;
              end
            end
            widx_d = widx_q + IDX_W'(1);
            if (widx_q == IDX_W'(NUM_WORDS - 1)) begin
              state_d      = S_EMIT;
              last_d       = 1'b0;
              pad_after_d  = 1'b0;
              marker_d     = 1'b0;
              first_d      = first_pend_q;
              first_pend_d = 1'b0;
            end
          end else begin
            // Final beat: rewrite the current word and every word after it in one edge.
            for (int i = 0; i < NUM_WORDS; i++) begin
              if ((IDX_W+1)'(i) >= {1'b0, widx_q}) begin
                we[i] = 1'b1;
                if (IDX_W'(i) == widx_q)
                  wdata[i] = pad_tail_word(bus.i_word, bus.i_nbytes);
                else if ((IDX_W+1)'(i) == marker_idx)
                  wdata[i] = MARKER_WORD;
                else if (len_fits && i == NUM_WORDS - 2)
                  wdata[i] = len_sum[LEN_W-1:WORD_W];
                else if (len_fits && i == NUM_WORDS - 1)
                  wdata[i] = len_sum[WORD_W-1:0];
              end
            end
            widx_d       = '0;
            state_d      = S_EMIT;
            last_d       = len_fits;
            pad_after_d  = !len_fits;
            marker_d     = (marker_idx == (IDX_W+1)'(NUM_WORDS));
            first_d      = first_pend_q;
            first_pend_d = 1'b0;
          end
        end
      end

      S_EMIT: begin
        if (bus.i_ready) begin
          widx_d  = '0;
          state_d = pad_after_q ? S_PAD : S_ABSORB;
          if (last_q) begin
            first_pend_d = 1'b1;
            len_d        = '0;
          end
        end
      end

      S_PAD: begin
        we = '1;
        wdata[0]             = marker_q ? MARKER_WORD : '0;
        wdata[NUM_WORDS - 2] = len_q[LEN_W-1:WORD_W];
        wdata[NUM_WORDS - 1] = len_q[WORD_W-1:0];
        state_d      = S_EMIT;
        last_d       = 1'b1;
        pad_after_d  = 1'b0;
        marker_d     = 1'b0;
        first_d      = first_pend_q;
        first_pend_d = 1'b0;
      end

      default: state_d = S_ABSORB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_ABSORB;
      widx_q       <= '0;
      len_q        <= '0;
      first_pend_q <= 1'b1;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      pad_after_q  <= 1'b0;
      marker_q     <= 1'b0;
      // NOTE: the word buffer is the o_block register, so it is reset like any other output.
      for (int i = 0; i < NUM_WORDS; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      widx_q       <= widx_d;
      len_q        <= len_d;
      first_pend_q <= first_pend_d;
      first_q      <= first_d;
      last_q       <= last_d;
      pad_after_q  <= pad_after_d;
      marker_q     <= marker_d;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (we[i]) buf_q[i] <= wdata[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++)
      bus.o_block[BLOCK_W-1-i*WORD_W -: WORD_W] = buf_q[i];
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: a table of message lengths against a byte-level
// padding model, plus hand-written backpressure and reset sequences.
module tb_sha256_padder;
  import sha256_pkg::*;

  typedef struct {
    int          len;
    bit          zero_tail;
    int          exp_blocks;
    logic [31:0] exp_len_lo;
    logic [31:0] exp_w0;
  } vec_t;

  typedef struct {
    logic [511:0] block;
    logic         first;
    logic         last;
  } blk_t;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  blk_t q[$];

  sha256_padder_if bus ();

  sha256_padder dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready)
      q.push_back('{bus.o_block, bus.o_first, bus.o_last});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int k);
    return 8'h30 + 8'((k + 1) % 10);
  endfunction

  function automatic logic [31:0] msg_word(input int w);
    return {msg_byte(4*w), msg_byte(4*w+1), msg_byte(4*w+2), msg_byte(4*w+3)};
  endfunction

  // Byte-level padding: message, 0x80, zeros up to 56 mod 64, then big-endian bit length.
  function automatic logic [511:0] model_block(input int len, input int b);
    logic [511:0] r;
    logic [63:0]  bits;
    logic [7:0]   by;
    int           total;
    int           k;
    r     = '0;
    bits  = 64'(len) * 64'd8;
    total = ((len + 8) / 64 + 1) * 64;
    for (int j = 0; j < 64; j++) begin
      k = b * 64 + j;
      if (k < len)              by = msg_byte(k);
      else if (k == len)        by = 8'h80;
      else if (k >= total - 8)  by = bits[8*(total-1-k) +: 8];
      else                      by = 8'h00;
      r = {r[503:0], by};
    end
    return r;
  endfunction

  task automatic send_beat(input logic [31:0] w, input logic last, input logic [2:0] nb);
    int t;
    bus.i_valid  = 1'b1;
    bus.i_word   = w;
    bus.i_last   = last;
    bus.i_nbytes = nb;
    t = 0;
    while (!bus.o_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_timeout", 512'(bus.o_ready), 512'(1));
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic send_msg(input int len, input bit zero_tail);
    int nfull;
    int rem;
    logic [31:0] w;
    nfull = len / 4;
    rem   = len % 4;
    if (len == 0) begin
      send_beat(32'h5A5A5A5A, 1'b1, 3'd0);
    end else if (rem != 0) begin
      for (int i = 0; i < nfull; i++) send_beat(msg_word(i), 1'b0, 3'd4);
      w = 32'hAAAAAAAA;
      for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg_byte(4*nfull + j);
      send_beat(w, 1'b1, 3'(rem));
    end else if (zero_tail) begin
      for (int i = 0; i < nfull; i++) send_beat(msg_word(i), 1'b0, 3'd4);
      send_beat(32'hDEADBEEF, 1'b1, 3'd0);
    end else begin
      for (int i = 0; i < nfull - 1; i++) send_beat(msg_word(i), 1'b0, 3'd4);
      send_beat(msg_word(nfull - 1), 1'b1, 3'd4);
    end
  endtask

  task automatic wait_blocks(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.o_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_timeout", 512'(bus.o_valid), 512'(1));
  endtask

  task automatic run_vector(input vec_t v);
    int nb;
    send_msg(v.len, v.zero_tail);
    wait_blocks(v.exp_blocks);
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("len%0d_count", v.len), 512'(q.size()), 512'(v.exp_blocks));
    nb = (q.size() < v.exp_blocks) ? q.size() : v.exp_blocks;
    for (int b = 0; b < nb; b++) begin
      check($sformatf("len%0d_blk%0d", v.len, b), q[b].block, model_block(v.len, b));
      check($sformatf("len%0d_first%0d", v.len, b), 512'(q[b].first), 512'(b == 0));
      check($sformatf("len%0d_last%0d", v.len, b), 512'(q[b].last), 512'(b == v.exp_blocks - 1));
    end
    if (nb > 0) begin
      check($sformatf("len%0d_w0", v.len), 512'(q[0].block[511:480]), 512'(v.exp_w0));
      check($sformatf("len%0d_lenlo", v.len), 512'(q[nb-1].block[31:0]), 512'(v.exp_len_lo));
    end
    q.delete();
  endtask

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{0,   1'b0, 1, 32'h000, 32'h80000000};
    vecs[1]  = '{3,   1'b0, 1, 32'h018, 32'h31323380};
    vecs[2]  = '{4,   1'b0, 1, 32'h020, 32'h31323334};
    vecs[3]  = '{8,   1'b1, 1, 32'h040, 32'h31323334};
    vecs[4]  = '{55,  1'b0, 1, 32'h1B8, 32'h31323334};
    vecs[5]  = '{56,  1'b0, 2, 32'h1C0, 32'h31323334};
    vecs[6]  = '{60,  1'b0, 2, 32'h1E0, 32'h31323334};
    vecs[7]  = '{64,  1'b0, 2, 32'h200, 32'h31323334};
    vecs[8]  = '{80,  1'b0, 2, 32'h280, 32'h31323334};
    vecs[9]  = '{119, 1'b0, 2, 32'h3B8, 32'h31323334};
    vecs[10] = '{120, 1'b0, 3, 32'h3C0, 32'h31323334};

    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_word   = '0;
    bus.i_last   = 1'b0;
    bus.i_nbytes = '0;
    bus.i_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_o_valid", 512'(bus.o_valid), 512'(0));
    check("rst_o_ready", 512'(bus.o_ready), 512'(1));
    check("rst_o_block", bus.o_block, '0);
    check("rst_o_first", 512'(bus.o_first), 512'(0));
    check("rst_o_last",  512'(bus.o_last),  512'(0));

    // "abc" with garbage in the ignored byte.
    send_beat(32'h616263FF, 1'b1, 3'd3);
    wait_blocks(1);
    check("abc_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      check("abc_block", q[0].block, ABC_BLOCK);
      check("abc_first", 512'(q[0].first), 512'(1));
      check("abc_last",  512'(q[0].last),  512'(1));
    end
    q.delete();

    for (int i = 0; i < 11; i++) run_vector(vecs[i]);

    // Backpressure: block must hold still and input must stay blocked.
    bus.i_ready = 1'b0;
    send_beat(32'h61626300, 1'b1, 3'd3);
    wait_valid();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_block_c%0d", c), bus.o_block, ABC_BLOCK);
      check($sformatf("bp_ready_c%0d", c), 512'(bus.o_ready), 512'(0));
    end
    bus.i_ready = 1'b1;
    wait_blocks(1);
    check("bp_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      check("bp_first", 512'(q[0].first), 512'(1));
      check("bp_last",  512'(q[0].last),  512'(1));
    end
    q.delete();

    // Asynchronous reset with a block pending.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(msg_word(i), 1'b0, 3'd4);
    wait_valid();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 512'(bus.o_valid), 512'(0));
    check("arst_o_block", bus.o_block, '0);
    check("arst_o_first", 512'(bus.o_first), 512'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;

    // Reset mid-message: partial words and length must be discarded.
    for (int i = 0; i < 3; i++) send_beat(msg_word(i), 1'b0, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(32'h61626300, 1'b1, 3'd3);
    wait_blocks(1);
    check("mrst_count", 512'(q.size()), 512'(1));
    if (q.size() > 0) begin
      check("mrst_block", q[0].block, ABC_BLOCK);
      check("mrst_first", 512'(q[0].first), 512'(1));
      check("mrst_last",  512'(q[0].last),  512'(1));
    end
    q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
